// File: rtl/panxi_pkg.sv
// Shared types and constants for the panxi core sleep/wake controller.
//   sleep_state_e        : controller FSM states (3-bit encoding)
//   SLEEP_DELAY_DEFAULT  : default idle window before the core clock is gated
//   WAKE_DELAY_DEFAULT   : default clock-running settle time before release
package panxi_pkg;

  typedef enum logic [2:0] {
    RESET_WAIT = 3'd0,
    RUN        = 3'd1,
    DRAIN      = 3'd2,
    SLEEP      = 3'd3,
    WAKE       = 3'd4
  } sleep_state_e;

  localparam int SLEEP_DELAY_DEFAULT = 4;
  localparam int WAKE_DELAY_DEFAULT  = 2;

endpackage

// File: rtl/panxi_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset (count returns to zero)
//   clr_i   : synchronous clear, takes priority over inc_i
//   inc_i   : increment by one, holding at all-ones once reached
//   count_o : registered count value
module panxi_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/panxi_sleep_ctrl.sv
// Core sleep/wake controller driving the enable of the core's latch-based
// clock-gate cell. Runs on the free-running clock.
//   clk_i          : free-running clock (never the gated clock)
//   rst_ni         : asynchronous active-low reset
//   fetch_enable_i : boot release, only looked at while waiting after reset
//   wfi_i          : core has retired a WFI (level)
//   core_busy_i    : fetch/LSU/multicycle activity still in flight
//   irq_pending_i  : enabled interrupt pending (level)
//   debug_req_i    : debug halt request (level)
//   clr_stats_i    : synchronous clear of sleep_cycles_o
//   clock_en_o     : registered enable to the clock-gate cell
//   core_sleep_o   : registered, core asleep or not yet released
//   wake_o         : one-cycle pulse on the first RUN cycle after WAKE
//   sleep_cycles_o : saturating count of cycles spent in SLEEP
module panxi_sleep_ctrl
  import panxi_pkg::*;
#(
  parameter int SLEEP_DELAY = SLEEP_DELAY_DEFAULT,
  parameter int WAKE_DELAY  = WAKE_DELAY_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_enable_i,
  input  logic        wfi_i,
  input  logic        core_busy_i,
  input  logic        irq_pending_i,
  input  logic        debug_req_i,
  input  logic        clr_stats_i,
  output logic        clock_en_o,
  output logic        core_sleep_o,
  output logic        wake_o,
  output logic [31:0] sleep_cycles_o
);

  localparam int MAX_DELAY = (SLEEP_DELAY > WAKE_DELAY) ? SLEEP_DELAY : WAKE_DELAY;
  localparam int CNT_W     = $clog2(MAX_DELAY + 1);

  localparam logic [CNT_W-1:0] SLEEP_LAST = CNT_W'(SLEEP_DELAY - 1);
  localparam logic [CNT_W-1:0] WAKE_LAST  = CNT_W'(WAKE_DELAY - 1);

  sleep_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clock_en_q, clock_en_d;
  logic             core_sleep_q, core_sleep_d;
  logic             wake_q, wake_d;
  logic             wake_cond;

  assign wake_cond = irq_pending_i | debug_req_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wake_d  = 1'b0;
    unique case (state_q)
      RESET_WAIT: begin
        if (fetch_enable_i) state_d = RUN;
      end
      RUN: begin
        // A pending wake source cancels the WFI outright.
        if (wfi_i && !wake_cond) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        // Aborting the drain is not a wake-up, so no wake_o pulse here.
        if (wake_cond || !wfi_i) begin
          state_d = RUN;
        end else if (core_busy_i) begin
          cnt_d = '0;
        end else if (cnt_q == SLEEP_LAST) begin
          state_d = SLEEP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SLEEP: begin
        if (wake_cond) begin
          state_d = WAKE;
          cnt_d   = '0;
        end
      end
      WAKE: begin
        // Committed once entered: the clock settles even if wake_cond drops.
        if (cnt_q == WAKE_LAST) begin
          state_d = RUN;
          wake_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = RESET_WAIT;
        cnt_d   = '0;
      end
    endcase

    // Outputs are decoded from the next state and registered, so the gate
    // enable never sees a combinational path from the inputs.
    clock_en_d   = (state_d == RUN) || (state_d == DRAIN) || (state_d == WAKE);
    core_sleep_d = (state_d == RESET_WAIT) || (state_d == SLEEP) || (state_d == WAKE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= RESET_WAIT;
      cnt_q        <= '0;
      clock_en_q   <= 1'b0;
      core_sleep_q <= 1'b1;
      wake_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      clock_en_q   <= clock_en_d;
      core_sleep_q <= core_sleep_d;
      wake_q       <= wake_d;
    end
  end

  panxi_sat_counter #(
    .WIDTH (32)
  ) u_sleep_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (clr_stats_i),
    .inc_i   (state_q == SLEEP),
    .count_o (sleep_cycles_o)
  );

  assign clock_en_o   = clock_en_q;
  assign core_sleep_o = core_sleep_q;
  assign wake_o       = wake_q;

endmodule
